udp_tx_packer: RTL and testbench

Packetizer stage directly upstream of the W5500 UDP transmit engine. Collects a free-running byte stream from the sampling logic into two ping-pong packet banks and, once a bank is complete, drives the engine's level transmit request, byte data and length. The engine drains the bank byte by byte through a read-enable. This removes the duplicate and over-fast UDP sends that occur when a raw sample strobe is tied straight to the request.

---
 rtl/udp_tx_pkg.sv | 17 +
 rtl/tx_bank_ram.sv | 27 ++
 rtl/udp_tx_packer.sv | 147 ++++++++++++++
 tb/tb_udp_tx_packer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_pkg.sv
// Shared types for the UDP transmit packetizer: length width, read FSM states
// and the bank/pointer types used by the top and the bench-facing logic.
package udp_tx_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } rd_state_e;

  typedef logic             bank_t;
  typedef logic [LEN_W-1:0] ptr_t;
  typedef logic [LEN_W-1:0] len_t;

endpackage

// File: rtl/tx_bank_ram.sv
// Simple dual-port byte RAM holding both ping-pong banks; address = {bank, ptr}.
// Registered read so it maps onto block RAM.
module tx_bank_ram #(
  parameter int DATA_W = 8,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_dat_p1
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    rd_dat_p1 <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_tx_packer.sv
// Ping-pong packetizer feeding the W5500 UDP transmit engine (level request, FWFT data).
// Optional partial-bank flush on idle: define UDP_TX_PACKER_TIMEOUT_EN.
module udp_tx_packer
  import udp_tx_pkg::*;
#(
  parameter int PKT_LEN     = 64,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_vld,
  input  logic [7:0]       din,
  output logic             o_dat_tx_req,
  input  logic             dat_tx_rden,
  output logic [7:0]       o_dat,
  output logic [LEN_W-1:0] o_dat_len,
  input  logic             dat_tx_end,
  output logic             o_drop
);

  localparam int   PW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam len_t PKT_LEN_L = len_t'(PKT_LEN);

  rd_state_e  state, state_nxt;
  bank_t      wr_bank, rd_bank, rd_bank_nxt, rd_next;
  ptr_t       rd_ptr, rd_ptr_nxt;
  len_t       len_nxt;
  logic [1:0] full;
  len_t       cnt [2];
  logic       accept, close, rel, to_fire;
  logic [PW:0] ram_waddr, ram_raddr;
  logic [7:0] rd_dat_p1;

  assign accept    = din_vld && !full[wr_bank];
  assign rel       = (state == REQ) && dat_tx_end;
  assign close     = (accept && ((cnt[wr_bank] + 16'd1) == PKT_LEN_L)) || to_fire;
  assign ram_waddr = {wr_bank, cnt[wr_bank][PW-1:0]};

`ifdef UDP_TX_PACKER_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_idle;

  assign to_idle = !din_vld && !full[wr_bank] && (cnt[wr_bank] != '0);
  assign to_fire = to_idle && (to_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (to_idle && !to_fire) begin
      to_cnt <= to_cnt + 32'd1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  // Write side: bank fill, close and release. Release and close never hit the
  // same bank because a released bank is full and the writer skips full banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= '0;
      cnt[0]  <= '0;
      cnt[1]  <= '0;
      wr_bank <= 1'b0;
      rd_next <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      o_drop <= din_vld && full[wr_bank];
      if (accept) begin
        cnt[wr_bank] <= cnt[wr_bank] + 16'd1;
      end
      if (close) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (rel) begin
        full[rd_bank] <= 1'b0;
        cnt[rd_bank]  <= '0;
        rd_next       <= ~rd_next;
      end
    end
  end

  tx_bank_ram #(
    .DATA_W (8),
    .AW     (PW + 1)
  ) u_ram (
    .clk       (clk),
    .wr_en     (accept),
    .wr_addr   (ram_waddr),
    .wr_dat    (din),
    .rd_addr   (ram_raddr),
    .rd_dat_p1 (rd_dat_p1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      rd_ptr    <= '0;
      o_dat_len <= '0;
    end else begin
      state     <= state_nxt;
      rd_bank   <= rd_bank_nxt;
      rd_ptr    <= rd_ptr_nxt;
      o_dat_len <= len_nxt;
    end
  end

  // Read address is the next-cycle pointer so the registered RAM output lines
  // up with rd_ptr, giving first-word-fall-through on o_dat.
  always_comb begin
    state_nxt   = state;
    rd_bank_nxt = rd_bank;
    rd_ptr_nxt  = rd_ptr;
    len_nxt     = o_dat_len;
    ram_raddr   = '0;
    case (state)
      IDLE: begin
        if (full[rd_next]) begin
          state_nxt   = REQ;
          rd_bank_nxt = rd_next;
          rd_ptr_nxt  = '0;
          len_nxt     = cnt[rd_next];
        end
      end
      REQ: begin
        if (dat_tx_rden && (rd_ptr != o_dat_len)) begin
          rd_ptr_nxt = rd_ptr + 16'd1;
        end
        if (dat_tx_end) begin
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    ram_raddr = {rd_bank_nxt, rd_ptr_nxt[PW-1:0]};
  end

  // Output stage: FWFT byte from the RAM register, zero past the end of packet
  assign o_dat_tx_req = (state == REQ);
  assign o_dat        = ((state == REQ) && (rd_ptr != o_dat_len)) ? rd_dat_p1 : 8'h00;

endmodule

// File: tb/tb_udp_tx_packer.sv
// Scoreboard bench for udp_tx_packer (PKT_LEN=4, TIMEOUT_CYC=10); an engine model
// drains banks while a monitor pops expected lengths and bytes from queues.
module tb_udp_tx_packer;

  localparam int PKT_LEN     = 4;
  localparam int TIMEOUT_CYC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_vld = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        o_dat_tx_req;
  logic        dat_tx_rden = 1'b0;
  logic [7:0]  o_dat;
  logic [15:0] o_dat_len;
  logic        dat_tx_end = 1'b0;
  logic        o_drop;

  udp_tx_packer #(
    .PKT_LEN     (PKT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din_vld      (din_vld),
    .din          (din),
    .o_dat_tx_req (o_dat_tx_req),
    .dat_tx_rden  (dat_tx_rden),
    .o_dat        (o_dat),
    .o_dat_len    (o_dat_len),
    .dat_tx_end   (dat_tx_end),
    .o_drop       (o_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q [$];
  int         len_q [$];
  int   drop_cnt = 0;
  int   req_cnt  = 0;
  logic req_prev = 1'b0;

  logic eng_en = 1'b0;
  int   eng_delay = 0;
  int   eng_rd_limit = 1000;
  logic eng_stalled = 1'b0;
  int   eng_n;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Engine model: waits for request, optional delay, reads len bytes, pulses end
  initial begin
    forever begin
      @(posedge clk); #1;
      if (eng_en && o_dat_tx_req && !rst) begin
        repeat (eng_delay) begin @(posedge clk); #1; end
        eng_n = int'(o_dat_len);
        if (eng_n > eng_rd_limit) eng_n = eng_rd_limit;
        for (int i = 0; i < eng_n; i++) begin
          dat_tx_rden = 1'b1;
          @(posedge clk); #1;
        end
        dat_tx_rden = 1'b0;
        if (eng_n < int'(o_dat_len)) begin
          eng_stalled = 1'b1;
          wait (!eng_en);
          eng_stalled = 1'b0;
        end else begin
          dat_tx_end = 1'b1;
          @(posedge clk); #1;
          dat_tx_end = 1'b0;
        end
      end
    end
  end

  // Monitor: compare length on each request rise and data on each read
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        req_prev = 1'b0;
      end else begin
        if (o_dat_tx_req && !req_prev) begin
          req_cnt++;
          if (len_q.size() == 0) check("unexpected_request", 1, 0);
          else check("o_dat_len", int'(o_dat_len), len_q.pop_front());
        end
        if (o_dat_tx_req && dat_tx_rden) begin
          if (exp_q.size() == 0) check("unexpected_read", int'(o_dat), -1);
          else check("o_dat", int'(o_dat), int'(exp_q.pop_front()));
        end
        if (o_drop) drop_cnt++;
        req_prev = o_dat_tx_req;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_byte(input logic [7:0] b);
    @(posedge clk); #1;
    din_vld = 1'b1;
    din     = b;
  endtask

  task automatic drive_idle();
    @(posedge clk); #1;
    din_vld = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || len_q.size() != 0 || o_dat_tx_req) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, int'(n < 400), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req"},  int'(o_dat_tx_req), 0);
    check({name, "_dat"},  int'(o_dat), 0);
    check({name, "_len"},  int'(o_dat_len), 0);
    check({name, "_drop"}, int'(o_drop), 0);
  endtask

  int d0, r0, n;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Full packet: request one cycle after last byte, FWFT data
    eng_delay = 2;
    eng_en    = 1'b1;
    len_q.push_back(4);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h33); drive_byte(8'h44);
    drive_idle();
    check("full_req_at_N", int'(o_dat_tx_req), 0);
    @(posedge clk); #1;
    check("full_req_at_N1", int'(o_dat_tx_req), 1);
    check("full_first_dat", int'(o_dat), 8'h11);
    check("full_len", int'(o_dat_len), 4);
    wait_drain("full");

    // Ping-pong with a slow engine
    eng_delay = 20;
    d0 = drop_cnt;
    r0 = req_cnt;
    len_q.push_back(4); len_q.push_back(4);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 8; i++) drive_byte(8'(i));
    drive_idle();
    wait_drain("pingpong");
    check("pingpong_drops", drop_cnt - d0, 0);
    check("pingpong_requests", req_cnt - r0, 2);

    // Overflow: engine idle, bytes 9..12 dropped
    eng_en    = 1'b0;
    eng_delay = 0;
    d0 = drop_cnt;
    len_q.push_back(4); len_q.push_back(4);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h81 + 8'(i));
    for (int i = 0; i < 12; i++) drive_byte(8'h81 + 8'(i));
    drive_idle();
    repeat (3) begin @(posedge clk); #1; end
    check("overflow_drops", drop_cnt - d0, 4);
    check("overflow_req_held", int'(o_dat_tx_req), 1);
    eng_en = 1'b1;
    wait_drain("overflow");
    check("overflow_drops_after_drain", drop_cnt - d0, 4);

    // Timeout flush of a partial bank
`ifdef UDP_TX_PACKER_TIMEOUT_EN
    len_q.push_back(2);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    drive_byte(8'hA5); drive_byte(8'h5A);
    drive_idle();
    repeat (10) begin @(posedge clk); #1; end
    check("timeout_req_early", int'(o_dat_tx_req), 0);
    @(posedge clk); #1;
    check("timeout_req_rise", int'(o_dat_tx_req), 1);
    check("timeout_len", int'(o_dat_len), 2);
    wait_drain("timeout");
`else
    r0 = req_cnt;
    drive_byte(8'hA5); drive_byte(8'h5A);
    drive_idle();
    repeat (40) begin @(posedge clk); #1; end
    check("no_timeout_req", int'(o_dat_tx_req), 0);
    check("no_timeout_requests", req_cnt - r0, 0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-drain, then a clean packet from bank 0
    eng_rd_limit = 2;
    len_q.push_back(4);
    exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    drive_byte(8'hC1); drive_byte(8'hC2); drive_byte(8'hC3); drive_byte(8'hC4);
    drive_idle();
    n = 0;
    while (!eng_stalled && n < 100) begin @(posedge clk); #1; n++; end
    check("middrain_stalled", int'(eng_stalled), 1);
    check("middrain_dat_before_rst", int'(o_dat), 8'hC3);
    rst = 1'b1;
    #1;
    check_reset_outputs("middrain_rst");
    eng_en = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    len_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    eng_rd_limit = 1000;
    eng_en = 1'b1;
    len_q.push_back(4);
    exp_q.push_back(8'hD1); exp_q.push_back(8'hD2);
    exp_q.push_back(8'hD3); exp_q.push_back(8'hD4);
    drive_byte(8'hD1); drive_byte(8'hD2); drive_byte(8'hD3); drive_byte(8'hD4);
    drive_idle();
    wait_drain("after_reset");

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
